// File: rtl/sfp_acc_bank.sv
// Per-column banked partial-sum accumulators with saturation, sticky overflow,
// bank clear, WS/OS store modes and a registered read port with optional ReLU.
module sfp_acc_bank #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int depth   = 16,
  parameter int addr_bw = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     mode,
  input  logic                     clr,
  input  logic                     acc_valid,
  input  logic                     acc_first,
  input  logic [addr_bw-1:0]       acc_addr,
  input  logic [psum_bw*col-1:0]   acc_in,
  input  logic                     rd_req,
  input  logic [addr_bw-1:0]       rd_addr,
  input  logic                     relu,
  output logic                     rd_valid,
  output logic [psum_bw*col-1:0]   rd_out,
  output logic [col-1:0]           ovf
);

  localparam int idx_bw = (depth > 1) ? $clog2(depth) : 1;
  localparam logic [addr_bw:0] depth_lim = (addr_bw+1)'(depth);

  logic [psum_bw-1:0]              bank_r [depth][col];
  logic [col-1:0]                  ovf_r;
  logic                            rd_valid_r;
  logic [col-1:0][psum_bw-1:0]     rd_out_r;

  logic                            acc_hit_s;
  logic                            rd_hit_s;
  logic [idx_bw-1:0]               acc_idx_s;
  logic [idx_bw-1:0]               rd_idx_s;
  logic [psum_bw-1:0]              old_s;
  logic [psum_bw-1:0]              in_s;
  logic [psum_bw-1:0]              raw_s;
  logic [psum_bw:0]                sum_s;
  logic [col-1:0][psum_bw-1:0]     wr_data_s;
  logic [col-1:0]                  wr_sat_s;
  logic [col-1:0][psum_bw-1:0]     rd_data_s;

  // Returns {clamped, value}; the sum is formed one bit wider so the sign-carry
  // disagreement exposes overflow and the sign of the true result picks the rail.
  function automatic logic [psum_bw:0] sat_add(input logic [psum_bw-1:0] a,
                                               input logic [psum_bw-1:0] b);
    logic [psum_bw:0] sum;
    sum = {a[psum_bw-1], a} + {b[psum_bw-1], b};
    if (sum[psum_bw] != sum[psum_bw-1]) begin
      if (sum[psum_bw]) begin
        sat_add = {1'b1, 1'b1, {(psum_bw-1){1'b0}}};
      end else begin
        sat_add = {1'b1, 1'b0, {(psum_bw-1){1'b1}}};
      end
    end else begin
      sat_add = {1'b0, sum[psum_bw-1:0]};
    end
  endfunction

  assign acc_hit_s = acc_valid && ({1'b0, acc_addr} < depth_lim);
  assign rd_hit_s  = {1'b0, rd_addr} < depth_lim;
  assign acc_idx_s = acc_addr[idx_bw-1:0];
  assign rd_idx_s  = rd_addr[idx_bw-1:0];

  // Per-column write data, saturation flags and ReLU-filtered read data.
  always_comb begin
    wr_data_s = '0;
    wr_sat_s  = '0;
    rd_data_s = '0;
    old_s     = '0;
    in_s      = '0;
    raw_s     = '0;
    sum_s     = '0;
    for (int c = 0; c < col; c++) begin
      in_s  = acc_in[psum_bw*c +: psum_bw];
      old_s = acc_hit_s ? bank_r[acc_idx_s][c] : '0;
      if (mode || acc_first) begin
        wr_data_s[c] = in_s;
        wr_sat_s[c]  = 1'b0;
      end else begin
        sum_s        = sat_add(old_s, in_s);
        wr_data_s[c] = sum_s[psum_bw-1:0];
        wr_sat_s[c]  = sum_s[psum_bw];
      end
      raw_s = rd_hit_s ? bank_r[rd_idx_s][c] : '0;
      if (relu && raw_s[psum_bw-1]) begin
        rd_data_s[c] = '0;
      end else begin
        rd_data_s[c] = raw_s;
      end
    end
  end

  // Bank storage, sticky overflow and registered read port.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int e = 0; e < depth; e++) begin
        for (int c = 0; c < col; c++) begin
          bank_r[e][c] <= '0;
        end
      end
      ovf_r      <= '0;
      rd_valid_r <= 1'b0;
      rd_out_r   <= '0;
    end else begin
      rd_valid_r <= rd_req;
      if (rd_req) begin
        rd_out_r <= rd_data_s;
      end else begin
        rd_out_r <= rd_out_r;
      end
      if (clr) begin
        for (int e = 0; e < depth; e++) begin
          for (int c = 0; c < col; c++) begin
            bank_r[e][c] <= '0;
          end
        end
        ovf_r <= '0;
      end else if (acc_hit_s) begin
        for (int c = 0; c < col; c++) begin
          bank_r[acc_idx_s][c] <= wr_data_s[c];
        end
        ovf_r <= ovf_r | wr_sat_s;
      end else begin
        ovf_r <= ovf_r;
      end
    end
  end

  assign rd_valid = rd_valid_r;
  assign rd_out   = rd_out_r;
  assign ovf      = ovf_r;

endmodule

// File: tb/tb_sfp_acc_bank.sv
// Directed self-checking bench for sfp_acc_bank (8 columns x 16-bit, 16 entries,
// 5-bit addresses so out-of-range addresses can be driven).
module tb_sfp_acc_bank;

  logic          clk = 1'b0;
  logic          reset, mode, clr, acc_valid, acc_first, rd_req, relu;
  logic [4:0]    acc_addr, rd_addr;
  logic [127:0]  acc_in;
  logic          rd_valid;
  logic [127:0]  rd_out;
  logic [7:0]    ovf;
  logic [127:0]  hold_v;
  int            checks = 0;
  int            errors = 0;

  always #5 clk = ~clk;

  sfp_acc_bank #(.col(8), .psum_bw(16), .depth(16), .addr_bw(5)) dut (
    .clk(clk), .reset(reset), .mode(mode), .clr(clr),
    .acc_valid(acc_valid), .acc_first(acc_first), .acc_addr(acc_addr),
    .acc_in(acc_in), .rd_req(rd_req), .rd_addr(rd_addr), .relu(relu),
    .rd_valid(rd_valid), .rd_out(rd_out), .ovf(ovf)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] cv(input int c, input logic [15:0] v);
    logic [127:0] r;
    r = '0;
    r[16*c +: 16] = v;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic acc(input logic [4:0] a, input logic first, input logic m, input logic [127:0] d);
    acc_valid = 1'b1; acc_first = first; mode = m; acc_addr = a; acc_in = d;
    tick();
    acc_valid = 1'b0; acc_first = 1'b0; mode = 1'b0; acc_in = '0;
  endtask

  task automatic rd(input logic [4:0] a, input logic r);
    rd_req = 1'b1; rd_addr = a; relu = r;
    tick();
    rd_req = 1'b0; relu = 1'b0;
  endtask

  initial begin
    reset = 1'b1; mode = 1'b0; clr = 1'b0; acc_valid = 1'b0; acc_first = 1'b0;
    rd_req = 1'b0; relu = 1'b0; acc_addr = '0; rd_addr = '0; acc_in = '0;
    tick(); tick();
    chk("rst_rd_valid", rd_valid, 1'b0);
    chk("rst_rd_out", rd_out, 128'd0);
    chk("rst_ovf", ovf, 8'h00);
    reset = 1'b0;

    rd(5'd0, 1'b0);
    chk("rst_e0_valid", rd_valid, 1'b1);
    chk("rst_e0_data", rd_out, 128'd0);
    rd(5'd15, 1'b0);
    chk("rst_e15_valid", rd_valid, 1'b1);
    chk("rst_e15_data", rd_out, 128'd0);
    chk("rst_ovf2", ovf, 8'h00);

    // WS accumulate on addr 3
    acc(5'd3, 1'b1, 1'b0, cv(0, 16'sd100));
    acc(5'd3, 1'b0, 1'b0, cv(0, 16'sd50));
    acc(5'd3, 1'b0, 1'b0, cv(0, -16'sd30));
    rd(5'd3, 1'b0);
    chk("ws_a3", rd_out, cv(0, 16'sd120));
    hold_v = rd_out;
    tick();
    chk("idle_valid", rd_valid, 1'b0);
    chk("idle_hold", rd_out, hold_v);

    // negative value with and without ReLU
    acc(5'd5, 1'b1, 1'b0, cv(1, -16'sd7));
    rd(5'd5, 1'b1);
    chk("relu_on", rd_out, 128'd0);
    rd(5'd5, 1'b0);
    chk("relu_off", rd_out, cv(1, -16'sd7));

    // saturation on both rails
    acc(5'd0, 1'b1, 1'b0, cv(0, 16'sd30000));
    acc(5'd0, 1'b0, 1'b0, cv(0, 16'sd5000));
    rd(5'd0, 1'b0);
    chk("sat_pos", rd_out, cv(0, 16'h7FFF));
    chk("sat_ovf0", ovf, 8'h01);
    acc(5'd0, 1'b0, 1'b0, cv(0, -16'sd100));
    rd(5'd0, 1'b0);
    chk("sat_back", rd_out, cv(0, 16'sd32667));
    chk("sat_ovf_sticky", ovf, 8'h01);
    acc(5'd4, 1'b1, 1'b0, cv(2, -16'sd30000));
    acc(5'd4, 1'b0, 1'b0, cv(2, -16'sd5000));
    rd(5'd4, 1'b0);
    chk("sat_neg", rd_out, cv(2, 16'h8000));
    chk("sat_ovf2", ovf, 8'h05);
    clr = 1'b1; tick(); clr = 1'b0;
    chk("clr_ovf", ovf, 8'h00);
    rd(5'd0, 1'b0);
    chk("clr_e0", rd_out, 128'd0);
    rd(5'd3, 1'b0);
    chk("clr_e3", rd_out, 128'd0);

    // same-cycle write/read hazard
    acc(5'd2, 1'b1, 1'b0, cv(0, 16'sd4));
    acc_valid = 1'b1; acc_addr = 5'd2; acc_in = cv(0, 16'sd10);
    rd_req = 1'b1; rd_addr = 5'd2;
    tick();
    acc_valid = 1'b0; acc_in = '0;
    chk("hazard_old", rd_out, cv(0, 16'sd4));
    tick();
    rd_req = 1'b0;
    chk("hazard_new", rd_out, cv(0, 16'sd14));

    // read in the clear cycle sees pre-clear data
    clr = 1'b1; rd_req = 1'b1; rd_addr = 5'd2;
    tick();
    clr = 1'b0; rd_req = 1'b0;
    chk("clr_rd_pre", rd_out, cv(0, 16'sd14));
    rd(5'd2, 1'b0);
    chk("clr_rd_post", rd_out, 128'd0);

    // OS pass-through and out-of-range addresses
    acc(5'd7, 1'b0, 1'b1, cv(0, 16'sd9));
    acc(5'd7, 1'b0, 1'b1, cv(0, 16'sd11));
    rd(5'd7, 1'b0);
    chk("os_a7", rd_out, cv(0, 16'sd11));
    acc(5'd16, 1'b1, 1'b0, cv(0, 16'sd77));
    rd(5'd16, 1'b0);
    chk("oor_rd_valid", rd_valid, 1'b1);
    chk("oor_rd_zero", rd_out, 128'd0);
    rd(5'd0, 1'b0);
    chk("oor_acc_dropped", rd_out, 128'd0);
    chk("oor_ovf", ovf, 8'h00);

    // clr beats acc_valid
    clr = 1'b1; acc_valid = 1'b1; acc_first = 1'b1; acc_addr = 5'd1; acc_in = cv(0, 16'sd5);
    tick();
    clr = 1'b0; acc_valid = 1'b0; acc_first = 1'b0; acc_in = '0;
    rd(5'd1, 1'b0);
    chk("clr_over_acc", rd_out, 128'd0);

    // reset beats everything
    acc(5'd6, 1'b1, 1'b0, cv(3, 16'sd33));
    acc(5'd0, 1'b1, 1'b0, cv(0, 16'h7FFF));
    acc(5'd0, 1'b0, 1'b0, cv(0, 16'sd1));
    rd(5'd6, 1'b0);
    chk("pre_rst_data", rd_out, cv(3, 16'sd33));
    chk("pre_rst_ovf", ovf, 8'h01);
    reset = 1'b1; clr = 1'b1; acc_valid = 1'b1; acc_addr = 5'd6; acc_in = cv(3, 16'sd1);
    rd_req = 1'b1; rd_addr = 5'd6;
    tick();
    reset = 1'b0; clr = 1'b0; acc_valid = 1'b0; acc_in = '0; rd_req = 1'b0;
    chk("mid_rst_valid", rd_valid, 1'b0);
    chk("mid_rst_out", rd_out, 128'd0);
    chk("mid_rst_ovf", ovf, 8'h00);
    rd(5'd6, 1'b0);
    chk("mid_rst_e6", rd_out, 128'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sfp_acc_bank.md
Name: sfp_acc_bank

Overview:
- Parametrised successor to the per-column SFP accumulators that sit after the OFIFO in the corelet.
- Each column owns a `depth`-entry signed partial-sum bank instead of a single register, so several output pixels or output channels accumulate concurrently.
- Adds saturating arithmetic, sticky per-column overflow flags, bank clear, WS/OS mode, and a registered read port with optional ReLU.
- Accumulate input is driven from the OFIFO output; the read port feeds the output SRAM writeback path.

Parameters:
- col, 8, number of columns/channels.
- psum_bw, 16, signed partial-sum width per column.
- depth, 16, entries per column bank (>=2, not necessarily a power of two).
- addr_bw, 4, address width; must satisfy 2^addr_bw >= depth.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- mode  input  1  0 = WS (accumulate), 1 = OS (store pass-through)
- clr  input  1  zero all entries and overflow flags
- acc_valid  input  1  accumulate/store request this cycle
- acc_first  input  1  overwrite entry instead of adding
- acc_addr  input  addr_bw  target entry
- acc_in  input  psum_bw*col  column c at [psum_bw*(c+1)-1 : psum_bw*c]
- rd_req  input  1  read request
- rd_addr  input  addr_bw  read entry
- relu  input  1  apply ReLU on read data
- rd_valid  output  1  read data valid
- rd_out  output  psum_bw*col  read data, same column packing as acc_in
- ovf  output  col  sticky per-column saturation flag

Behaviour:
- Single clock `clk`; reset is synchronous and active-high. On reset: all entries = 0, rd_valid = 0, rd_out = 0, ovf = 0. Reset overrides every other input.
- Storage: col x depth registers; all updates happen at the clk edge.
- Priority: reset > clr > acc_valid.
  - clr: every entry and all ovf bits go to 0 at the edge; acc_valid is ignored that cycle.
  - A read issued in the same cycle as clr returns the pre-clear contents.
- Accumulate (acc_valid=1, acc_addr < depth), per column c:
  - If mode=1 or acc_first=1: entry <= acc_in[c].
  - Otherwise: entry <= sat(entry + acc_in[c]).
  - Addition is signed two's complement at psum_bw+1 bits.
  - Result > 2^(psum_bw-1)-1 clamps to max; result < -2^(psum_bw-1) clamps to min. Either clamp sets ovf[c], which stays set until reset or clr.
- acc_addr >= depth: request dropped, no state change, ovf unchanged.
- Read (rd_req=1 at cycle t):
  - rd_valid=1 and rd_out valid in cycle t+1.
  - rd_out is the entry value at the start of cycle t, so a same-cycle write to the same address is NOT visible; a write in cycle t-1 or earlier is visible.
  - If relu=1 (sampled at t), negative columns read as 0; stored contents are never modified by relu.
  - rd_addr >= depth returns all-zero data with rd_valid=1.
- rd_req=0 at t: rd_valid=0 at t+1 and rd_out holds its previous value.
- Back-to-back reads and accumulates are sustained every cycle; there is no backpressure, and reads and accumulates to different or equal addresses may proceed in the same cycle.
- mode may change between any two cycles; it affects only that cycle's accumulate.

Test Plan:
- Reset then read entries 0 and 15 -> rd_valid one cycle later, rd_out = 0, ovf = 0.
- WS, psum_bw=16, addr 3:
  - acc_first with col0 = 100, then acc +50, then acc -30, then read -> col0 = 120.
  - Repeat on addr 5 with col1 = -7 and relu=1 -> addr 5 col1 reads 0; read again with relu=0 -> -7.
- Saturation:
  - addr 0, acc_first 30000, then acc +5000 -> reads 32767 and ovf[0]=1.
  - Subsequent acc -100 -> 32667 with ovf[0] still 1.
  - clr -> entry 0 and ovf = 0.
- Same-cycle hazard: in cycle t, acc addr 2 +10 (old value 4) and rd_req addr 2 -> rd_out 4 at t+1; read at t+1 -> 14 at t+2.
- OS mode: mode=1, acc to addr 7 with 9, then acc with 11 (acc_first=0) -> reads 11. acc_addr=16 with depth=16 -> dropped; rd_addr=16 -> rd_valid=1, rd_out = 0.
- Priority: reset asserted mid-stream while acc_valid and clr are active -> next cycle all outputs and entries are 0. clr together with acc_valid addr 1 = 5 -> entry 1 reads 0.
